// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 87;
    localparam int FRAME_BITS       = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Frame window: start + 8 data + stop, plus idle guard bits.
    function automatic int frame_cycles(input int gap_bits, input int clks_per_bit);
        return (FRAME_BITS + gap_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and transmitter-side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_send;
    logic [7:0]           tx_byte;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 done;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_send, tx_byte, grant_id, busy, done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_send, tx_byte, grant_id, busy, done
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: first valid requester after the last grant.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]    i_last,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_any
);

    logic [ID_W-1:0] w_cand [NUM_REQ];

    // w_cand[k] is the requester at priority position k (0 = highest).
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign w_cand[gi] = ID_W'((int'(i_last) + gi + 1) % NUM_REQ);
        end
    endgenerate

    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req_valid[w_cand[k]]) begin
                o_winner = w_cand[k];
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among several byte producers; the
// controller owns frame timing since the transmitter has no busy output.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int GAP_BITS     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int FRAME_CYCLES = frame_cycles(GAP_BITS, CLKS_PER_BIT);
    localparam int CNT_W        = $clog2(FRAME_CYCLES);
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [ID_W-1:0] r_last;
    logic            r_tx_send;
    logic [7:0]      r_tx_byte;
    logic [ID_W-1:0] r_grant_id;
    logic            r_done;

    logic [ID_W-1:0] w_winner;
    logic            w_any;
    logic            w_idle;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req_valid (bus.req_valid),
        .i_last      (r_last),
        .o_winner    (w_winner),
        .o_any       (w_any)
    );

    assign w_idle = (r_state == IDLE);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = w_idle && w_any && (w_winner == ID_W'(gi));
        end
    endgenerate

    assign bus.busy     = !w_idle;
    assign bus.tx_send  = r_tx_send;
    assign bus.tx_byte  = r_tx_byte;
    assign bus.grant_id = r_grant_id;
    assign bus.done     = r_done;

    // Reset lands in WAIT so a frame still leaving the unreset transmitter is not overlapped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WAIT;
            r_cnt      <= CNT_LOAD;
            r_last     <= LAST_INIT;
            r_tx_send  <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_grant_id <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_tx_byte  <= bus.req_data[int'(w_winner) * 8 +: 8];
                        r_grant_id <= w_winner;
                        r_last     <= w_winner;
                        r_tx_send  <= 1'b1;
                        r_state    <= PULSE;
                    end
                end
                PULSE: begin
                    r_tx_send <= 1'b0;
                    r_cnt     <= CNT_LOAD;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a time-based
// reference: grants happen when the line is free, then block for a fixed window.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int FRAME   = 957;
    localparam int SPACING = FRAME + 2;

    logic clk;
    logic rst_n;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .CLKS_PER_BIT (87),
        .GAP_BITS     (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: cycle index since reset release, time the line becomes free,
    // time of the last grant, round-robin pointer and last granted byte/id.
    int         t;
    int         free_at;
    int         grant_t;
    int         last_ptr;
    int         exp_id;
    logic [7:0] exp_byte;
    int         grants;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic int rr_winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic reset_model();
        t        = 0;
        free_at  = FRAME;
        grant_t  = -10;
        last_ptr = N - 1;
        exp_id   = 0;
        exp_byte = 8'h00;
    endtask

    // One clock cycle: check at the falling edge, advance the model, return after the rising edge.
    task automatic step();
        logic       busy_e;
        logic [N-1:0] ready_e;
        int         w;
        @(negedge clk);
        busy_e  = (t < free_at);
        w       = rr_winner(bus.req_valid, last_ptr);
        ready_e = '0;
        if (!busy_e && w >= 0) ready_e[w] = 1'b1;
        chk("busy",     32'(bus.busy),      32'(busy_e));
        chk("done",     32'(bus.done),      32'(t == free_at));
        chk("req_ready", 32'(bus.req_ready), 32'(ready_e));
        chk("tx_send",  32'(bus.tx_send),   32'(t == grant_t + 1));
        chk("tx_byte",  32'(bus.tx_byte),   32'(exp_byte));
        chk("grant_id", 32'(bus.grant_id),  32'(exp_id));
        if (ready_e != '0) begin
            $display("grant t=%0d id=%0d byte=%02h", t, w, bus.req_data[8*w +: 8]);
            grants++;
            grant_t  = t;
            free_at  = t + SPACING;
            last_ptr = w;
            exp_id   = w;
            exp_byte = bus.req_data[8*w +: 8];
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic check_in_reset();
        chk("rst_tx_send",   32'(bus.tx_send),   32'(0));
        chk("rst_tx_byte",   32'(bus.tx_byte),   32'(0));
        chk("rst_busy",      32'(bus.busy),      32'(1));
        chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_done",      32'(bus.done),      32'(0));
    endtask

    initial begin
        grants        = 0;
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check_in_reset();
        rst_n = 1'b1;

        // Reset window then continuous round-robin 0,1,2,3,0
        run(FRAME + 5 * SPACING + 5);

        // Single byte from requester 2
        bus.req_valid = '0;
        run(SPACING);
        bus.req_valid = 4'b0100;
        bus.req_data  = {8'h33, 8'hA5, 8'h11, 8'h00};
        step();
        bus.req_valid = '0;
        run(SPACING + 10);

        // Fairness: grant 1, then 1010 must alternate 3,1
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = 4'b1010;
        bus.req_data  = {8'hD3, 8'h00, 8'hB1, 8'h00};
        run(3 * SPACING);

        // Late request mid-WAIT, then a request raised and withdrawn inside WAIT
        bus.req_valid = '0;
        run(SPACING);
        bus.req_valid = 4'b0001;
        bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h5C};
        run(300);
        bus.req_valid = 4'b0001;
        run(SPACING);
        bus.req_valid = '0;
        run(300);
        bus.req_valid = 4'b1000;
        run(50);
        bus.req_valid = '0;
        run(SPACING);
        bus.req_valid = 4'b1001;
        run(2 * SPACING);

        // Randomized requests, data changes and withdrawals
        for (int i = 0; i < 25000; i++) begin
            if ($urandom_range(63) == 0) bus.req_valid = 4'($urandom);
            if ($urandom_range(15) == 0) bus.req_data = 32'($urandom);
            step();
        end

        // Reset 300 cycles into a frame window
        bus.req_valid = '1;
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        run(SPACING + 2);
        while (t != grant_t + 2 + 300 && t < grant_t + SPACING) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_in_reset();
        repeat (3) @(posedge clk);
        #1;
        check_in_reset();
        rst_n = 1'b1;
        reset_model();
        run(FRAME + SPACING + 5);

        chk("grant_count_nonzero", 32'(grants > 20), 32'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one `uart_tx` transmitter among NUM_REQ byte producers using round-robin arbitration.
- Each accepted byte is driven to the transmitter with a one-cycle `send` pulse. The transmitter starts a frame on the falling edge of `send`.
- `tx_byte` is held stable for the whole frame, because `uart_tx` samples its byte input bit-by-bit.
- The next grant is blocked until the frame plus a guard gap has elapsed. `uart_tx` has no busy output, so the controller owns frame timing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 87, clocks per UART bit; must equal the transmitter's value.
- GAP_BITS, 1, extra idle bit times after each frame. Must be ≥1 so the stop bit is full length.
- FRAME_CYCLES, (10+GAP_BITS)*CLKS_PER_BIT, derived, not overridable. Default is 957.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_ready  out  NUM_REQ  byte of requester i accepted this cycle
- tx_send  out  1  to uart_tx `send`
- tx_byte  out  8  to uart_tx `Tx_Byte`
- grant_id  out  $clog2(NUM_REQ)  last granted requester
- busy  out  1  frame in progress; no grant possible
- done  out  1  one-cycle pulse at end of each frame window

Behaviour:
- States: IDLE, PULSE, WAIT.
- Reset state:
  - state=WAIT, cnt=FRAME_CYCLES-1, tx_send=0, tx_byte=0x00, grant_id=0, done=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Entering WAIT on reset guarantees no overlap with a frame the unreset transmitter may still be sending.
  - A frame interrupted by reset may be corrupted; this is accepted.
- busy = (state != IDLE).
- req_ready is combinational:
  - req_ready[i] = (state==IDLE) && req_valid[i] && (winner==i).
  - At most one bit is set.
  - Zero in PULSE and WAIT.
- Winner: the first i with req_valid[i], searching last+1, last+2, … modulo NUM_REQ.
- IDLE:
  - If any req_valid: transfer occurs this cycle. tx_byte<=req_data[winner], grant_id<=winner, last<=winner, tx_send<=1, go to PULSE.
  - Else stay in IDLE.
- PULSE (1 cycle): tx_send<=0, cnt<=FRAME_CYCLES-1, go to WAIT. The transmitter sees the falling edge during the first WAIT cycle.
- WAIT:
  - If cnt != 0: cnt decrements.
  - If cnt == 0: done<=1 for one cycle, go to IDLE.
  - tx_byte is held throughout.
- Grant spacing under continuous demand: FRAME_CYCLES+2 cycles (959 with defaults).
- Registered outputs: tx_send, tx_byte, grant_id, done.
- cnt width: $clog2(FRAME_CYCLES). No wrap; it is reloaded before use.
- req_valid deasserted before the grant: no transfer and no state change. A requester may withdraw freely.
- req_valid asserted during PULSE or WAIT: ignored until IDLE; the requester holds valid and data.
- Simultaneous requests: exactly one is granted per frame, and the pointer rotates only on a grant.
- tx_byte retains its last value in IDLE; it is not cleared.

Decomposition:
- Package uart_pkg:
  - CLKS_PER_BIT default and FRAME_BITS=10.
  - State enum {IDLE, PULSE, WAIT}.
- One sub-module, uart_rr_pick:
  - Combinational rotating-priority picker.
  - Inputs: req_valid, last. Outputs: winner, any.
- Counter and FSM live in uart_tx_arbiter.

Test Plan:
1. Reset behaviour: assert rst_n=0, release it, hold all req_valid=1.
   - tx_send=0, tx_byte=0x00, busy=1 and req_ready=0 for 957 cycles.
   - Then done=1 for one cycle, busy=0, and req_ready[0]=1.
2. Single byte: only req_valid[2]=1 with data 0xA5.
   - req_ready[2] pulses once; next cycle tx_send=1, tx_byte=0xA5, grant_id=2.
   - busy stays high for 958 cycles after the grant, then done pulses.
   - With the uart_tx model attached, the line shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1.
3. Continuous round-robin: all four valid with data 0x10..0x13 held.
   - Grant order is 0,1,2,3,0.
   - Successive req_ready pulses are exactly 959 cycles apart.
   - tx_byte sequence is 0x10, 0x11, 0x12, 0x13, 0x10.
4. Fairness: after granting requester 1, present req_valid=4'b1010.
   - Grant goes to 3, then to 1; requester 1 is never granted twice in a row.
5. Late and withdrawn requests:
   - Assert req_valid[0] mid-WAIT: req_ready stays 0 until IDLE, then it is granted.
   - Assert and drop req_valid[3] within WAIT: no grant, and the pointer is unchanged.
6. Reset mid-frame: drop rst_n 300 cycles into WAIT.
   - tx_send and tx_byte go to 0 immediately and busy=1.
   - After release, 957 cycles pass before the first grant, and requester 0 has priority.
